// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline-register chain.
// The entry layout is {data, tag, wr}, packed MSB to LSB.
package pipe_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 3;
    localparam int TAG_W_DEF = 5;

    // Register 0 is hard-wired, so it never takes part in forwarding.
    localparam int TAG_ZERO  = 0;

    // Flat width of one {data, tag, wr} entry.
    function automatic int entry_w(input int width, input int tag_w);
        return width + tag_w + 1;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a flat {data, tag, wr} entry register.
// The payload only loads when a live entry arrives, so empty slots keep
// their stale payload and do not toggle.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int EW = entry_w(WIDTH_DEF, TAG_W_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          load_valid,
    input  logic [EW-1:0] load_entry,
    input  logic          flush,
    output logic          valid,
    output logic [EW-1:0] entry
);

    // Valid follows the incoming entry on a load; a held entry that is flushed is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= load_valid;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

    // Payload captures only live incoming entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry <= '0;
        end else if (load && load_valid) begin
            entry <= load_entry;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline-register chain: DEPTH stages with valid/ready backpressure,
// bubble collapse, per-stage flush, occupancy count and a forwarding lookup.
// Stage 0 is the youngest (input side), stage DEPTH-1 the oldest.
// Optional build macro PIPE_SKID_EN adds a one-entry skid register after the
// last stage so that in_ready no longer depends combinationally on out_ready.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_wr,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_wr,
    input  logic [TAG_W-1:0]           q_tag,
    output logic                       fwd_hit,
    output logic [WIDTH-1:0]           fwd_data,
    output logic [$clog2(DEPTH):0]     fwd_stage,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);

    localparam int EW = entry_w(WIDTH, TAG_W);
    localparam int SW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(DEPTH + 2);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             wr;
    } entry_t;

    entry_t          in_entry;
    entry_t          head;
    entry_t          st     [DEPTH];
    logic [EW-1:0]   st_raw [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] rdy;

    assign in_entry = {in_data, in_tag, in_wr};
    assign live     = v & ~flush;
    assign in_ready = rdy[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          ld_valid;
        logic [EW-1:0] ld_entry;

        if (i == 0) begin : g_first
            assign ld_valid = in_valid;
            assign ld_entry = in_entry;
        end else begin : g_next
            assign ld_valid = live[i-1];
            assign ld_entry = st_raw[i-1];
        end

        pipe_stage #(.EW(EW)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (rdy[i]),
            .load_valid (ld_valid),
            .load_entry (ld_entry),
            .flush      (flush[i]),
            .valid      (v[i]),
            .entry      (st_raw[i])
        );

        assign st[i] = st_raw[i];
    end

`ifdef PIPE_SKID_EN
    logic   skid_full;
    entry_t skid;

    // Skid catches the oldest entry when the consumer stalls, and empties once it is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_full <= 1'b0;
            skid      <= '0;
        end else if (skid_full) begin
            if (out_ready) begin
                skid_full <= 1'b0;
            end
        end else if (live[DEPTH-1] && !out_ready) begin
            skid_full <= 1'b1;
            skid      <= st[DEPTH-1];
        end
    end

    assign out_valid = skid_full | live[DEPTH-1];
    assign head      = skid_full ? skid : st[DEPTH-1];
`else
    assign out_valid = live[DEPTH-1];
    assign head      = st[DEPTH-1];
`endif

    assign out_data = head.data;
    assign out_tag  = head.tag;
    assign out_wr   = head.wr;

    // Ready ripples from the output back to stage 0; any empty or flushed slot collapses the bubble.
    always_comb begin
        logic chain;
`ifdef PIPE_SKID_EN
        chain = ~skid_full;
`else
        chain = ~live[DEPTH-1] | out_ready;
`endif
        rdy = '0;
        rdy[DEPTH-1] = chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            chain  = ~live[i] | chain;
            rdy[i] = chain;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest matching live writer wins.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        fwd_stage = '0;
`ifdef PIPE_SKID_EN
        if (skid_full && skid.wr && skid.tag == q_tag && q_tag != TAG_W'(TAG_ZERO)) begin
            fwd_hit   = 1'b1;
            fwd_data  = skid.data;
            fwd_stage = SW'(DEPTH);
        end
`endif
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (live[i] && st[i].wr && st[i].tag == q_tag && q_tag != TAG_W'(TAG_ZERO)) begin
                fwd_hit   = 1'b1;
                fwd_data  = st[i].data;
                fwd_stage = SW'(i);
            end
        end
    end

    // Occupancy counts registered valid bits, ignoring this cycle's flush.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OW'(v[i]);
        end
`ifdef PIPE_SKID_EN
        occupancy = occupancy + OW'(skid_full);
`endif
    end

endmodule
